// File: rtl/sound_event_synth.sv
// sound_event_synth: turns game event edges into prioritised, queued square-wave tones with a button-toggled mute.
// Define SOUND_DECAY_EN to make the high level halve every DECAY_CYC cycles during a tone.
module sound_event_synth #(
  parameter int N_CH = 3,
  parameter int DAC_W = 8,
  parameter logic [DAC_W-1:0] AMP = 8'hC0,
  parameter int BASE_HP = 4,
  parameter int STEP_HP = 2,
  parameter int DUR_CYC = 32,
  parameter int GAP_CYC = 4,
  parameter int DECAY_CYC = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_CH-1:0]                         event_i,
  input  logic                                    button_i,
  output logic [DAC_W-1:0]                        dacCount,
  output logic                                    busy_o,
  output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] chan_o,
  output logic                                    mute_o
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int HP_MAX = BASE_HP + (N_CH - 1) * STEP_HP;
  localparam int HPW = HP_MAX > 1 ? $clog2(HP_MAX) : 1;
  localparam int DW = DUR_CYC > 1 ? $clog2(DUR_CYC) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [N_CH-1:0]  ev_q, ev_edge, pend_q, pend_d, sel;
  logic             btn_q, btn_edge, mute_q, mute_d, phase_q, phase_d, start, retrig;
  logic [CW-1:0]    chan_q, chan_d, nxt;
  logic [DW-1:0]    dur_q, dur_d;
  logic [HPW-1:0]   hp_q, hp_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DAC_W-1:0] dac_q, dac_d, lvl_d;

  function automatic logic [CW-1:0] lowest(input logic [N_CH-1:0] v);
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (v[i]) lowest = CW'(i);
  endfunction

  function automatic logic [HPW-1:0] hp_load(input logic [CW-1:0] c);
    return HPW'(BASE_HP + int'(c) * STEP_HP - 1);
  endfunction

  always_comb begin
    btn_edge = button_i & ~btn_q;
    ev_edge = mute_q ? '0 : event_i & ~ev_q;
    mute_d = mute_q ^ btn_edge;
    state_d = state_q;
    chan_d = chan_q;
    dur_d = dur_q;
    hp_d = hp_q;
    phase_d = phase_q;
    gap_d = gap_q;
    start = 1'b0;
    retrig = 1'b0;
    nxt = chan_q;
    case (state_q)
      IDLE: begin
        start = |ev_edge || |pend_q;
        nxt = |ev_edge ? lowest(ev_edge) : lowest(pend_q);
      end
      PLAY: begin
        start = |ev_edge && lowest(ev_edge) < chan_q;
        nxt = start ? lowest(ev_edge) : chan_q;
        retrig = !start && ev_edge[chan_q];
        hp_d = hp_q == '0 ? hp_load(chan_q) : hp_q - 1'b1;
        phase_d = phase_q ^ (hp_q == '0);
        dur_d = retrig ? DW'(DUR_CYC - 1) : dur_q - 1'b1;
      end
      GAP: begin
        start = gap_q == '0;
        nxt = lowest(pend_q | ev_edge);
        gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // the channel being started or retriggered never stays queued
    sel = start || retrig ? N_CH'(1) << nxt : '0;
    pend_d = (pend_q | ev_edge) & ~sel;
    if (state_q == PLAY && !start && !retrig && dur_q == '0) begin
      state_d = |pend_d ? GAP : IDLE;
      chan_d = |pend_d ? chan_q : '0;
      gap_d = GW'(GAP_CYC - 1);
    end
    if (start) begin
      state_d = PLAY;
      chan_d = nxt;
      dur_d = DW'(DUR_CYC - 1);
      hp_d = hp_load(nxt);
      phase_d = 1'b1;
    end
    if (btn_edge && !mute_q) begin
      state_d = IDLE;
      chan_d = '0;
      pend_d = '0;
    end
  end

`ifdef SOUND_DECAY_EN
  localparam int KW = DECAY_CYC > 1 ? $clog2(DECAY_CYC) : 1;
  logic [DAC_W-1:0] lvl_q;
  logic [KW-1:0]    dec_q, dec_d;

  always_comb begin
    lvl_d = lvl_q;
    dec_d = dec_q;
    if (start || retrig) begin
      lvl_d = AMP;
      dec_d = KW'(DECAY_CYC - 1);
    end else if (state_q == PLAY) begin
      lvl_d = dec_q == '0 ? lvl_q >> 1 : lvl_q;
      dec_d = dec_q == '0 ? KW'(DECAY_CYC - 1) : dec_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
      dec_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      dec_q <= dec_d;
    end
  end
`else
  assign lvl_d = AMP;
`endif

  assign dac_d = state_d == PLAY && phase_d ? lvl_d : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ev_q <= '0;
      btn_q <= 1'b0;
      mute_q <= 1'b0;
      pend_q <= '0;
      chan_q <= '0;
      dur_q <= '0;
      hp_q <= '0;
      gap_q <= '0;
      phase_q <= 1'b0;
      dac_q <= '0;
    end else begin
      state_q <= state_d;
      ev_q <= event_i;
      btn_q <= button_i;
      mute_q <= mute_d;
      pend_q <= pend_d;
      chan_q <= chan_d;
      dur_q <= dur_d;
      hp_q <= hp_d;
      gap_q <= gap_d;
      phase_q <= phase_d;
      dac_q <= dac_d;
    end
  end

  assign dacCount = dac_q;
  assign busy_o = state_q != IDLE;
  assign chan_o = chan_q;
  assign mute_o = mute_q;
endmodule

// File: tb/tb_sound_event_synth.sv
// tb_sound_event_synth: directed and random stimulus against a timestamp-based model of the tone scheduler.
module tb_sound_event_synth;
  localparam int BASE_HP = 4, STEP_HP = 2, DUR_CYC = 32, GAP_CYC = 4, DECAY_CYC = 8;
  localparam logic [7:0] AMP = 8'hC0;

  logic       clk = 1'b0, rst = 1'b1, button_i = 1'b0;
  logic [2:0] event_i = '0;
  logic [7:0] dacCount;
  logic       busy_o, mute_o;
  logic [1:0] chan_o;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sound_event_synth dut (
    .clk(clk), .rst(rst), .event_i(event_i), .button_i(button_i),
    .dacCount(dacCount), .busy_o(busy_o), .chan_o(chan_o), .mute_o(mute_o)
  );

  // model: tones are described by timestamps (start, end, level origin) rather than counters
  int n = 0;
  int m_mode = 0, m_ch = 0, m_s = 0, m_end = 0, m_lt = 0, m_gend = 0;
  logic [2:0] m_pend = '0, pev = '0;
  logic m_mute = 1'b0, pbtn = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic int first(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic play(input int c);
    m_mode = 1; m_ch = c; m_s = n; m_end = n + DUR_CYC - 1; m_lt = n; m_pend[c] = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] ev, input logic btn, input logic r);
    logic [2:0] e;
    logic b;
    if (r) begin
      m_mode = 0; m_ch = 0; m_pend = '0; m_mute = 1'b0; pev = '0; pbtn = 1'b0;
      return;
    end
    e = m_mute ? 3'b000 : ev & ~pev;
    b = btn & ~pbtn;
    pev = ev; pbtn = btn;
    if (b && !m_mute) begin
      m_mute = 1'b1; m_mode = 0; m_pend = '0; m_ch = 0;
      return;
    end
    if (b) m_mute = 1'b0;
    case (m_mode)
      0: if (e != 0) begin m_pend |= e; play(first(e)); end
         else if (m_pend != 0) play(first(m_pend));
      1: if (e != 0 && first(e) < m_ch) begin m_pend |= e; play(first(e)); end
         else begin
           if (e[m_ch]) begin m_end = n + DUR_CYC - 1; m_lt = n; e[m_ch] = 1'b0; end
           m_pend |= e;
           if (n > m_end) begin
             if (m_pend != 0) begin m_mode = 2; m_gend = n + GAP_CYC; end
             else begin m_mode = 0; m_ch = 0; end
           end
         end
      default: begin
        m_pend |= e;
        if (n == m_gend) play(first(m_pend));
      end
    endcase
  endtask

  function automatic logic [7:0] exp_dac();
    if (m_mode != 1 || ((n - m_s) / (BASE_HP + m_ch * STEP_HP)) % 2 == 1) return 8'h00;
`ifdef SOUND_DECAY_EN
    return AMP >> ((n - m_lt) / DECAY_CYC);
`else
    return AMP;
`endif
  endfunction

  task automatic step(input logic [2:0] ev, input logic b, input logic r);
    event_i = ev; button_i = b; rst = r;
    @(posedge clk);
    model_step(ev, b, r);
    #1;
    check("dac", dacCount, exp_dac());
    check("busy", busy_o, m_mode != 0);
    check("chan", chan_o, m_ch);
    check("mute", mute_o, m_mute);
    n++;
  endtask

  task automatic idle(input int k);
    repeat (k) step(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] rev;
    logic rbtn;
    int cnt;
    step(3'b111, 1'b0, 1'b1);
    step(3'b111, 1'b0, 1'b1);
    check("reset_dac", dacCount, 8'h00);
    step(3'b111, 1'b0, 1'b0);
    check("release_dac", dacCount, AMP);
    check("release_chan", chan_o, 0);
    // simultaneous edges: release above, then a fresh 000->111
    for (int pass = 0; pass < 2; pass++) begin
      cnt = busy_o;
      repeat (115) begin step(3'b111, 1'b0, 1'b0); cnt += busy_o; end
      check("sim_busy", cnt, 104);
      idle(3);
      cnt = 0;
      step(3'b111, 1'b0, 1'b0);
      cnt = busy_o;
      repeat (115) begin step(3'b111, 1'b0, 1'b0); cnt += busy_o; end
      check("sim_busy2", cnt, 104);
      idle(3);
    end
    // single ch1 tone, half-period 6
    step(3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("tone", dacCount, (i < 32 && (i / 6) % 2 == 0) ? AMP : 8'h00);
      if (i == 31) check("tone_busy_end", busy_o, 1);
      if (i == 32) check("tone_busy_off", busy_o, 0);
      step(3'b000, 1'b0, 1'b0);
    end
    // pre-emption of ch2 by ch0; ch2 must not return
    step(3'b100, 1'b0, 1'b0);
    repeat (9) step(3'b100, 1'b0, 1'b0);
    step(3'b101, 1'b0, 1'b0);
    check("preempt_chan", chan_o, 0);
    check("preempt_dac", dacCount, AMP);
    cnt = 0;
    repeat (50) begin step(3'b101, 1'b0, 1'b0); cnt += (chan_o == 2'd2); end
    check("preempt_no_replay", cnt, 0);
    idle(5);
    // ch2 queued behind ch0 plays once after the gap
    step(3'b001, 1'b0, 1'b0);
    repeat (5) step(3'b001, 1'b0, 1'b0);
    cnt = 0;
    repeat (80) begin step(3'b101, 1'b0, 1'b0); cnt += (busy_o && chan_o == 2'd2); end
    check("queued_ch2_cycles", cnt, 32);
    idle(5);
    // mute mid-tone with a pending channel
    step(3'b001, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0);
    repeat (3) step(3'b011, 1'b0, 1'b0);
    step(3'b011, 1'b1, 1'b0);
    check("mute_on", mute_o, 1);
    check("mute_dac", dacCount, 8'h00);
    check("mute_busy", busy_o, 0);
    step(3'b000, 1'b0, 1'b0);
    cnt = 0;
    repeat (20) begin step(3'b100, 1'b0, 1'b0); cnt += busy_o; end
    check("muted_silent", cnt, 0);
    step(3'b000, 1'b1, 1'b0);
    check("mute_off", mute_o, 0);
    step(3'b010, 1'b0, 1'b0);
    check("unmuted_play", dacCount, AMP);
    idle(40);
    // level envelope over one ch0 tone
    step(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
`ifdef SOUND_DECAY_EN
      check("level", dacCount, (i / 4) % 2 == 0 ? AMP >> (i / 8) : 8'h00);
`else
      check("level", dacCount, (i / 4) % 2 == 0 ? AMP : 8'h00);
`endif
      step(3'b000, 1'b0, 1'b0);
    end
    idle(5);
    // random traffic
    rev = '0;
    rbtn = 1'b0;
    repeat (4000) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 29) == 0) rev[i] = ~rev[i];
      if ($urandom_range(0, 149) == 0) rbtn = ~rbtn;
      step(rev, rbtn, $urandom_range(0, 1499) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
